// File: rtl/div64by32_if.sv
// Start/busy/done handshake and operand/result bundle for the div64by32 divider.
interface div64by32_if #(parameter int W = 32);
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/div64by32.sv
// Sequential restoring divider, 2W/W -> W quotient + W remainder, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (truncating toward zero).
module div64by32 #(
  parameter int W = 32
) (
  input  logic       clk,
  input  logic       rst,
  div64by32_if.slave bus
);
  localparam int CW = $clog2(W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [W-1:0]   rem_q;
  logic [W-1:0]   shreg;
  logic [W:0]     dvs;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   quo_r, rem_r;
  logic           busy_r, done_r, dbz_r, ovf_r;

  logic [2*W-1:0] dnd_mag;
  logic [W:0]     dvs_mag;
  logic [W:0]     shifted;
  logic           ge;
  logic [W-1:0]   rem_next, quo_next;
  logic           hi_ovf;

  // Partial remainder always stays below the divisor, so W bits hold it;
  // the shifted value needs the extra bit for the compare.
  assign shifted  = {rem_q, shreg[W-1]};
  assign ge       = shifted >= dvs;
  assign rem_next = ge ? W'(shifted - dvs) : shifted[W-1:0];
  // Quotient bits enter at the bottom as dividend bits leave the top.
  assign quo_next = {shreg[W-2:0], ge};
  assign hi_ovf   = {1'b0, dnd_mag[2*W-1:W]} >= dvs_mag;

`ifdef DIV_SIGNED_EN
  localparam logic [W-1:0] QMIN = {1'b1, {(W-1){1'b0}}};

  logic         dnd_neg, dvs_neg;
  logic [W:0]   dvs_sx;
  logic         neg_q, neg_r;
  logic [W-1:0] lo_cap;
  logic         q_ovf;

  assign dnd_neg = bus.dividend[2*W-1];
  assign dvs_neg = bus.divisor[W-1];
  assign dvs_sx  = {bus.divisor[W-1], bus.divisor};
  assign dnd_mag = dnd_neg ? (~bus.dividend + (2*W)'(1)) : bus.dividend;
  // W+1 bits so the most-negative divisor has a representable magnitude.
  assign dvs_mag = dvs_neg ? (~dvs_sx + (W+1)'(1)) : dvs_sx;
  assign q_ovf   = neg_q ? (quo_next > QMIN) : quo_next[W-1];
`else
  assign dnd_mag = bus.dividend;
  assign dvs_mag = {1'b0, bus.divisor};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rem_q  <= '0;
      shreg  <= '0;
      dvs    <= '0;
      cnt    <= '0;
      quo_r  <= '0;
      rem_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      ovf_r  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      lo_cap <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dbz_r <= 1'b0;
            ovf_r <= 1'b0;
            rem_q <= dnd_mag[2*W-1:W];
            shreg <= dnd_mag[W-1:0];
            dvs   <= dvs_mag;
            cnt   <= '0;
`ifdef DIV_SIGNED_EN
            neg_q  <= dnd_neg ^ dvs_neg;
            neg_r  <= dnd_neg;
            lo_cap <= bus.dividend[W-1:0];
`endif
            if (bus.divisor == '0) begin
              done_r <= 1'b1;
              dbz_r  <= 1'b1;
              quo_r  <= '1;
              rem_r  <= bus.dividend[W-1:0];
            end else if (hi_ovf) begin
              done_r <= 1'b1;
              ovf_r  <= 1'b1;
              quo_r  <= '1;
              rem_r  <= bus.dividend[W-1:0];
            end else begin
              busy_r <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= rem_next;
          shreg <= quo_next;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(W-1)) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
`ifdef DIV_SIGNED_EN
            if (q_ovf) begin
              ovf_r <= 1'b1;
              quo_r <= '1;
              rem_r <= lo_cap;
            end else begin
              quo_r <= neg_q ? (~quo_next + W'(1)) : quo_next;
              rem_r <= neg_r ? (~rem_next + W'(1)) : rem_next;
            end
`else
            quo_r <= quo_next;
            rem_r <= rem_next;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.overflow    = ovf_r;
endmodule

// File: tb/tb_div64by32.sv
// Directed self-checking bench for div64by32 (default unsigned build; signed
// expectations apply when DIV_SIGNED_EN is defined).
module tb_div64by32;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

`ifdef DIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  div64by32_if #(.W(32)) bus();
  div64by32 #(.W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Issue one op from 1ns after an edge; returns edges from acceptance to done.
  task automatic run_op(input logic [63:0] a, input logic [31:0] b,
                        output int lat, output logic busy0);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy0 = bus.busy;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_chk++; if ({bus.quotient, bus.remainder} !== 64'h0) begin n_fail++; $display("FAIL reset_qr: got %h_%h want 0", bus.quotient, bus.remainder); end
    n_chk++; if ({bus.div_by_zero, bus.overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b%b want 00", bus.div_by_zero, bus.overflow); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic b0;
    run_op(64'd100, 32'd7, lat, b0);
    n_chk++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", b0); end
    n_chk++; if (lat !== 32) begin n_fail++; $display("FAIL basic_latency: got %0d want 32", lat); end
    n_chk++; if (bus.quotient !== 32'd14) begin n_fail++; $display("FAIL basic_q: got %h want %h", bus.quotient, 32'd14); end
    n_chk++; if (bus.remainder !== 32'd2) begin n_fail++; $display("FAIL basic_r: got %h want %h", bus.remainder, 32'd2); end
    n_chk++; if ({bus.div_by_zero, bus.overflow, bus.busy} !== 3'b000) begin n_fail++; $display("FAIL basic_flags: got %b%b%b want 000", bus.div_by_zero, bus.overflow, bus.busy); end
    @(posedge clk); #1;
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
    n_chk++; if (bus.quotient !== 32'd14) begin n_fail++; $display("FAIL basic_q_hold: got %h want %h", bus.quotient, 32'd14); end
  endtask

  task automatic test_full_width();
    int lat; logic b0;
    run_op(64'h0000_0000_FFFF_FFFF, 32'h10, lat, b0);
    n_chk++; if ({bus.quotient, bus.remainder} !== {32'h0FFF_FFFF, 32'hF}) begin n_fail++; $display("FAIL fw1_qr: got %h_%h want 0fffffff_0000000f", bus.quotient, bus.remainder); end
    @(posedge clk); #1;
    run_op(64'h0000_0001_0000_0000, 32'd2, lat, b0);
    // 2^31 is not a representable positive signed quotient.
    n_chk++; if (bus.overflow !== SGN) begin n_fail++; $display("FAIL fw2_ovf: got %b want %b", bus.overflow, SGN); end
    n_chk++; if (bus.quotient !== (SGN ? 32'hFFFF_FFFF : 32'h8000_0000)) begin n_fail++; $display("FAIL fw2_q: got %h", bus.quotient); end
    n_chk++; if (bus.remainder !== 32'h0) begin n_fail++; $display("FAIL fw2_r: got %h want 0", bus.remainder); end
    n_chk++; if (lat !== 32) begin n_fail++; $display("FAIL fw2_latency: got %0d want 32", lat); end
    @(posedge clk); #1;
    // High half one below divisor: largest non-overflowing unsigned case.
    run_op({32'd4, 32'hFFFF_FFFF}, 32'd5, lat, b0);
    n_chk++; if (bus.overflow !== SGN) begin n_fail++; $display("FAIL edge_ovf: got %b want %b", bus.overflow, SGN); end
    n_chk++; if ({bus.quotient, bus.remainder} !== (SGN ? {32'hFFFF_FFFF, 32'hFFFF_FFFF} : {32'hFFFF_FFFF, 32'd4})) begin n_fail++; $display("FAIL edge_qr: got %h_%h", bus.quotient, bus.remainder); end
  endtask

  task automatic test_errors();
    int lat; logic b0;
    @(posedge clk); #1;
    run_op(64'h1234, 32'd0, lat, b0);
    n_chk++; if (lat !== 0) begin n_fail++; $display("FAIL dbz_latency: got %0d want 0", lat); end
    n_chk++; if (b0 !== 1'b0) begin n_fail++; $display("FAIL dbz_busy: got %b want 0", b0); end
    n_chk++; if ({bus.div_by_zero, bus.overflow} !== 2'b10) begin n_fail++; $display("FAIL dbz_flags: got %b%b want 10", bus.div_by_zero, bus.overflow); end
    n_chk++; if ({bus.quotient, bus.remainder} !== {32'hFFFF_FFFF, 32'h1234}) begin n_fail++; $display("FAIL dbz_qr: got %h_%h want ffffffff_00001234", bus.quotient, bus.remainder); end
    // Issued in the done cycle of the previous error: back-to-back errors.
    run_op(64'h0000_0005_0000_0000, 32'd5, lat, b0);
    n_chk++; if (lat !== 0) begin n_fail++; $display("FAIL ovf_latency: got %0d want 0", lat); end
    n_chk++; if ({bus.div_by_zero, bus.overflow} !== 2'b01) begin n_fail++; $display("FAIL ovf_flags: got %b%b want 01", bus.div_by_zero, bus.overflow); end
    n_chk++; if ({bus.quotient, bus.remainder} !== {32'hFFFF_FFFF, 32'h0}) begin n_fail++; $display("FAIL ovf_qr: got %h_%h want ffffffff_00000000", bus.quotient, bus.remainder); end
    @(posedge clk); #1;
    n_chk++; if ({bus.done, bus.overflow} !== 2'b01) begin n_fail++; $display("FAIL ovf_hold: got done=%b ovf=%b want 0 1", bus.done, bus.overflow); end
  endtask

  task automatic test_ignore_start();
    int lat;
    bus.start = 1'b1; bus.dividend = 64'd1000; bus.divisor = 32'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    repeat (9) begin @(posedge clk); #1; lat++; end
    bus.start = 1'b1; bus.dividend = 64'd999; bus.divisor = 32'd3;
    @(posedge clk); #1; lat++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    n_chk++; if (lat !== 32) begin n_fail++; $display("FAIL ignore_latency: got %0d want 32", lat); end
    n_chk++; if ({bus.quotient, bus.remainder} !== {32'd100, 32'd0}) begin n_fail++; $display("FAIL ignore_qr: got %h_%h want 00000064_00000000", bus.quotient, bus.remainder); end
    @(posedge clk); #1;
    n_chk++; if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("FAIL ignore_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_back_to_back();
    int lat; logic b0;
    run_op(64'd100, 32'd7, lat, b0);
    n_chk++; if (bus.quotient !== 32'd14) begin n_fail++; $display("FAIL b2b_first_q: got %h want 0000000e", bus.quotient); end
    run_op(64'h0000_0000_FFFF_FFFF, 32'h1_0000, lat, b0);
    n_chk++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b want 1", b0); end
    n_chk++; if (lat !== 32) begin n_fail++; $display("FAIL b2b_latency: got %0d want 32", lat); end
    n_chk++; if ({bus.quotient, bus.remainder} !== {32'hFFFF, 32'hFFFF}) begin n_fail++; $display("FAIL b2b_qr: got %h_%h want 0000ffff_0000ffff", bus.quotient, bus.remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_signed();
    int lat; logic b0;
    run_op(64'hFFFF_FFFF_FFFF_FF9C, 32'd7, lat, b0);
    if (SGN) begin
      n_chk++; if ({bus.quotient, bus.remainder} !== {32'hFFFF_FFF2, 32'hFFFF_FFFE}) begin n_fail++; $display("FAIL sgn_neg_qr: got %h_%h want fffffff2_fffffffe", bus.quotient, bus.remainder); end
    end else begin
      // Unsigned: high half 0xFFFFFFFF >= 7 overflows immediately.
      n_chk++; if ({bus.overflow, bus.quotient, bus.remainder} !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF9C}) begin n_fail++; $display("FAIL uns_big_qr: got %b %h_%h want 1 ffffffff_ffffff9c", bus.overflow, bus.quotient, bus.remainder); end
    end
    @(posedge clk); #1;
    run_op(64'h0000_0000_8000_0000, 32'd1, lat, b0);
    n_chk++; if (bus.overflow !== SGN) begin n_fail++; $display("FAIL sgn_2p31_ovf: got %b want %b", bus.overflow, SGN); end
    n_chk++; if ({bus.quotient, bus.remainder} !== (SGN ? {32'hFFFF_FFFF, 32'h8000_0000} : {32'h8000_0000, 32'h0})) begin n_fail++; $display("FAIL sgn_2p31_qr: got %h_%h", bus.quotient, bus.remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int seen_done, seen_busy;
    bus.start = 1'b1; bus.dividend = 64'd1000; bus.divisor = 32'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    rst = 1'b1; bus.start = 1'b1; bus.dividend = 64'd50; bus.divisor = 32'd5;
    @(posedge clk); #1;
    n_chk++; if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("FAIL rstmid_busy_done: got %b%b want 00", bus.busy, bus.done); end
    n_chk++; if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== 66'h0) begin n_fail++; $display("FAIL rstmid_outputs: got %h_%h %b%b want zeros", bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow); end
    rst = 1'b0; bus.start = 1'b0;
    seen_done = 0; seen_busy = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen_done++;
      if (bus.busy === 1'b1) seen_busy++;
    end
    n_chk++; if (seen_done !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d done cycles want 0", seen_done); end
    n_chk++; if (seen_busy !== 0) begin n_fail++; $display("FAIL rstmid_no_accept: got %0d busy cycles want 0", seen_busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_width();
    test_errors();
    test_ignore_start();
    test_back_to_back();
    test_signed();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
